sram_slot_arbiter: RTL and testbench



---
 rtl/sram_slot_arbiter_if.sv | 41 ++++
 rtl/sram_slot_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_sram_slot_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_slot_arbiter_if.sv
// Client and SRAM-side bundle of the shared SRAM slot arbiter.
// The arbiter owns the o_* signals, clients and pins own the i_* signals.
interface sram_slot_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16
);
    logic                          i_start;
    logic [NUM_CLIENTS-1:0]        i_client_en;
    logic                          i_clr_status;
    logic [NUM_CLIENTS*ADDR_W-1:0] i_addr;
    logic [NUM_CLIENTS-1:0]        i_we_n;
    logic [NUM_CLIENTS*DATA_W-1:0] i_wdata;
    logic [NUM_CLIENTS-1:0]        i_done;

    logic [NUM_CLIENTS-1:0]        o_grant;
    logic [ADDR_W-1:0]             o_sram_addr;
    logic                          o_sram_we_n;
    logic [DATA_W-1:0]             o_sram_wdata;
    logic                          o_sram_drive;
    logic                          o_busy;
    logic                          o_round_done;
    logic                          o_overrun;
    logic [NUM_CLIENTS-1:0]        o_timeout;

    modport slave (
        input  i_start, i_client_en, i_clr_status,
        input  i_addr, i_we_n, i_wdata, i_done,
        output o_grant, o_sram_addr, o_sram_we_n,
        output o_sram_wdata, o_sram_drive,
        output o_busy, o_round_done, o_overrun, o_timeout
    );

    modport master (
        output i_start, i_client_en, i_clr_status,
        output i_addr, i_we_n, i_wdata, i_done,
        input  o_grant, o_sram_addr, o_sram_we_n,
        input  o_sram_wdata, o_sram_drive,
        input  o_busy, o_round_done, o_overrun, o_timeout
    );
endinterface

// File: rtl/sram_slot_arbiter.sv
// Token-ring time-slot arbiter for the shared async SRAM.
// One round per sample: enabled clients own the bus in ascending order.
module sram_slot_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int TURN_GAP    = 1,
    parameter int TIMEOUT     = 32
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    sram_slot_arbiter_if.slave      bus
);
    localparam int IDX_W = $clog2(NUM_CLIENTS);
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [1:0] GAP_INIT =
        (TURN_GAP > 0) ? 2'(TURN_GAP - 1) : 2'd0;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_CLIENTS-1:0] mask_q, mask_d;
    logic [1:0]             gap_q, gap_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [NUM_CLIENTS-1:0] grant_q, grant_d;
    logic                   busy_q, busy_d;
    logic                   rd_q, rd_d;
    logic                   ovr_q, ovr_d;
    logic [NUM_CLIENTS-1:0] to_q, to_d;

    logic [IDX_W-1:0]       low_idx;
    logic                   low_any;
    logic [IDX_W-1:0]       nxt_idx;
    logic                   nxt_any;
    logic                   done_hit;
    logic                   wd_exp;

    // Lowest enabled client at round start, next latched client above idx_q.
    always_comb begin
        low_idx = '0;
        low_any = 1'b0;
        nxt_idx = '0;
        nxt_any = 1'b0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (bus.i_client_en[k]) begin
                low_idx = IDX_W'(k);
                low_any = 1'b1;
            end
            if (mask_q[k] && (k > int'(idx_q))) begin
                nxt_idx = IDX_W'(k);
                nxt_any = 1'b1;
            end
        end
    end

    // Round sequencing: slot handover, turnaround gap, watchdog and flags.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        gap_d    = gap_q;
        wd_d     = wd_q;
        grant_d  = grant_q;
        rd_d     = 1'b0;
        ovr_d    = 1'b0;
        to_d     = bus.i_clr_status ? '0 : to_q;
        done_hit = bus.i_done[idx_q];
        wd_exp   = (wd_q == WD_LAST);
        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    mask_d = bus.i_client_en;
                    if (low_any) begin
                        state_d = GRANT;
                        idx_d   = low_idx;
                        grant_d = NUM_CLIENTS'(1) << low_idx;
                        wd_d    = '0;
                    end else begin
                        rd_d = 1'b1;
                    end
                end
            end
            GRANT: begin
                ovr_d = bus.i_start;
                if (done_hit || wd_exp) begin
                    // done in the last watchdog cycle is a clean release
                    if (!done_hit) begin
                        to_d[idx_q] = 1'b1;
                    end
                    grant_d = '0;
                    wd_d    = '0;
                    if (nxt_any) begin
                        idx_d = nxt_idx;
                        if (TURN_GAP == 0) begin
                            grant_d = NUM_CLIENTS'(1) << nxt_idx;
                        end else begin
                            state_d = GAP;
                            gap_d   = GAP_INIT;
                        end
                    end else begin
                        state_d = IDLE;
                        rd_d    = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            GAP: begin
                ovr_d = bus.i_start;
                if (gap_q == 2'd0) begin
                    state_d = GRANT;
                    grant_d = NUM_CLIENTS'(1) << idx_q;
                    wd_d    = '0;
                end else begin
                    gap_d = gap_q - 2'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs; reset aborts any round in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            gap_q   <= '0;
            wd_q    <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            rd_q    <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            gap_q   <= gap_d;
            wd_q    <= wd_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            rd_q    <= rd_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    logic [ADDR_W-1:0] mux_addr;
    logic [DATA_W-1:0] mux_wdata;
    logic              mux_we_n;
    logic              mux_drive;

    // SRAM pin mux follows the registered grant; idle bus is a safe read.
    always_comb begin
        mux_addr  = '0;
        mux_wdata = '0;
        mux_we_n  = 1'b1;
        mux_drive = 1'b0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            if (grant_q[k]) begin
                mux_addr  = bus.i_addr[k*ADDR_W +: ADDR_W];
                mux_wdata = bus.i_wdata[k*DATA_W +: DATA_W];
                mux_we_n  = bus.i_we_n[k];
                mux_drive = ~bus.i_we_n[k];
            end
        end
    end

    assign bus.o_grant      = grant_q;
    assign bus.o_sram_addr  = mux_addr;
    assign bus.o_sram_we_n  = mux_we_n;
    assign bus.o_sram_wdata = mux_wdata;
    assign bus.o_sram_drive = mux_drive;
    assign bus.o_busy       = busy_q;
    assign bus.o_round_done = rd_q;
    assign bus.o_overrun    = ovr_q;
    assign bus.o_timeout    = to_q;
endmodule

// File: tb/tb_sram_slot_arbiter.sv
// Bench for sram_slot_arbiter: directed scenarios plus random rounds
// compared each cycle against a queue-based model of the slot rules.
module tb_sram_slot_arbiter;
    localparam int N  = 4;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int TG = 1;
    localparam int TO = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sram_slot_arbiter_if #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) bus_if ();

    sram_slot_arbiter #(
        .NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW),
        .TURN_GAP(TG), .TIMEOUT(TO)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_if)
    );

    int errors = 0;
    int checks = 0;

    // model of the round: pending clients, current owner, its slot age
    int          m_owner = -1;
    int          m_age   = 0;
    int          m_gap   = 0;
    bit          m_busy  = 1'b0;
    bit          m_rd    = 1'b0;
    bit          m_ovr   = 1'b0;
    logic [N-1:0] m_to   = '0;
    int          m_q[$];

    int  hold[N];
    bit  rnd_mode = 1'b0;
    bit  cmp_en   = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic m_take_next();
        m_owner = m_q.pop_front();
        m_age   = 1;
    endtask

    // Reference model: advances on every edge from the sampled inputs.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_age = 0; m_gap = 0;
                m_busy = 0; m_rd = 0; m_ovr = 0; m_to = '0;
                m_q.delete();
            end else begin
                bit rel;
                m_rd  = 0;
                m_ovr = 0;
                if (bus_if.i_clr_status) m_to = '0;
                if (!m_busy) begin
                    if (bus_if.i_start) begin
                        m_q.delete();
                        for (int k = 0; k < N; k++)
                            if (bus_if.i_client_en[k]) m_q.push_back(k);
                        if (m_q.size() == 0) m_rd = 1;
                        else begin
                            m_take_next();
                            m_busy = 1;
                        end
                    end
                end else begin
                    if (bus_if.i_start) m_ovr = 1;
                    if (m_owner >= 0) begin
                        rel = 0;
                        if (bus_if.i_done[m_owner]) rel = 1;
                        else if (m_age == TO) begin
                            rel = 1;
                            m_to[m_owner] = 1'b1;
                        end else m_age++;
                        if (rel) begin
                            m_owner = -1;
                            if (m_q.size() == 0) begin
                                m_busy = 0;
                                m_rd = 1;
                            end else if (TG == 0) m_take_next();
                            else m_gap = TG;
                        end
                    end else begin
                        m_gap--;
                        if (m_gap == 0) m_take_next();
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && cmp_en) begin
                logic [N-1:0]  eg;
                logic [AW-1:0] ea;
                logic [DW-1:0] ed;
                logic          ew;
                eg = '0; ea = '0; ed = '0; ew = 1'b1;
                if (m_owner >= 0) begin
                    eg[m_owner] = 1'b1;
                    ea = bus_if.i_addr[m_owner*AW +: AW];
                    ed = bus_if.i_wdata[m_owner*DW +: DW];
                    ew = bus_if.i_we_n[m_owner];
                end
                chk("ctl", {bus_if.o_grant, bus_if.o_busy, bus_if.o_round_done,
                            bus_if.o_overrun, bus_if.o_timeout},
                           {eg, m_busy, m_rd, m_ovr, m_to});
                chk("mux", {bus_if.o_sram_addr, bus_if.o_sram_wdata,
                            bus_if.o_sram_we_n, bus_if.o_sram_drive},
                           {ea, ed, ew, ~ew});
            end
        end
    end

    // One clock; clients release after hold[k] cycles of ownership.
    task automatic step();
        @(posedge clk);
        #1;
        bus_if.i_done = '0;
        if (rnd_mode) begin
            if ($urandom_range(0, 7) == 0) bus_if.i_done = N'($urandom);
            for (int k = 0; k < N; k++) begin
                bus_if.i_addr[k*AW +: AW]  = AW'($urandom);
                bus_if.i_wdata[k*DW +: DW] = DW'($urandom);
            end
            bus_if.i_we_n       = N'($urandom);
            bus_if.i_client_en  = N'($urandom);
            bus_if.i_clr_status = ($urandom_range(0, 49) == 0);
            bus_if.i_start      = ($urandom_range(0, 19) == 0);
            if (bus_if.i_start && !m_busy) begin
                for (int k = 0; k < N; k++) begin
                    case ($urandom_range(0, 7))
                        0: hold[k] = 0;
                        1: hold[k] = TO;
                        default: hold[k] = int'($urandom_range(1, 5));
                    endcase
                end
            end
        end
        if (m_owner >= 0 && hold[m_owner] != 0 && m_age == hold[m_owner])
            bus_if.i_done[m_owner] = 1'b1;
    endtask

    // Runs from the first grant cycle until round_done, tallying slots.
    task automatic run_round(string nm, output int n, output int cnt[N],
                             output int gaps);
        n = 0; gaps = 0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        while (!bus_if.o_round_done && n < 400) begin
            for (int k = 0; k < N; k++) if (bus_if.o_grant[k]) cnt[k]++;
            if (bus_if.o_busy && bus_if.o_grant == '0) gaps++;
            step();
            n++;
        end
        chk({nm, "_bound"}, 64'(n < 400), 64'd1);
    endtask

    task automatic set_hold(int h);
        for (int k = 0; k < N; k++) hold[k] = h;
    endtask

    task automatic start_round(logic [N-1:0] en);
        bus_if.i_client_en = en;
        bus_if.i_start = 1'b1;
        step();
        bus_if.i_start = 1'b0;
    endtask

    initial begin
        int n, gaps, w;
        int cnt[N];
        bus_if.i_start = 0; bus_if.i_client_en = '0;
        bus_if.i_clr_status = 0; bus_if.i_addr = '0;
        bus_if.i_we_n = '1; bus_if.i_wdata = '0; bus_if.i_done = '0;
        set_hold(3);
        #12;
        chk("rst_grant", 64'(bus_if.o_grant), 64'd0);
        chk("rst_we_n", 64'(bus_if.o_sram_we_n), 64'd1);
        chk("rst_flags", {bus_if.o_busy, bus_if.o_round_done,
                          bus_if.o_overrun, bus_if.o_sram_drive}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmp_en = 1'b1;
        step();

        // full round, 3-cycle slots, one gap cycle between them
        start_round(4'b1111);
        chk("t1_first", 64'(bus_if.o_grant), 64'b0001);
        run_round("t1", n, cnt, gaps);
        chk("t1_len", 64'(n), 64'd15);
        chk("t1_slot2", 64'(cnt[2]), 64'd3);
        chk("t1_gaps", 64'(gaps), 64'd3);
        step();

        // skipped clients, enable changes mid-round ignored
        start_round(4'b1010);
        chk("t2_first", 64'(bus_if.o_grant), 64'b0010);
        bus_if.i_client_en = 4'b1111;
        run_round("t2", n, cnt, gaps);
        chk("t2_skipped", 64'(cnt[0] + cnt[2]), 64'd0);
        chk("t2_slot3", 64'(cnt[3]), 64'd3);
        chk("t2_len", 64'(n), 64'd7);
        step();

        // client 2 hangs and is cut off by the watchdog
        set_hold(2);
        hold[2] = 0;
        start_round(4'b1111);
        run_round("t3", n, cnt, gaps);
        chk("t3_slot2", 64'(cnt[2]), 64'd32);
        chk("t3_slot3", 64'(cnt[3]), 64'd2);
        chk("t3_flag", 64'(bus_if.o_timeout), 64'b0100);
        bus_if.i_clr_status = 1'b1;
        step();
        bus_if.i_clr_status = 1'b0;
        chk("t3_clr", 64'(bus_if.o_timeout), 64'd0);

        // start pulse while busy only raises overrun
        set_hold(3);
        start_round(4'b1111);
        w = 0;
        while (bus_if.o_grant != 4'b0010 && w < 50) begin
            step();
            w++;
        end
        chk("t4_reach", 64'(w < 50), 64'd1);
        bus_if.i_start = 1'b1;
        step();
        bus_if.i_start = 1'b0;
        chk("t4_ovr", 64'(bus_if.o_overrun), 64'd1);
        step();
        chk("t4_ovr_end", 64'(bus_if.o_overrun), 64'd0);
        run_round("t4", n, cnt, gaps);
        chk("t4_order", 64'(cnt[3]), 64'd3);
        repeat (5) step();
        chk("t4_idle", 64'(bus_if.o_busy), 64'd0);

        // client 0 write cycle drives DQ, the following gap does not
        bus_if.i_we_n = 4'b1110;
        bus_if.i_addr[0 +: AW] = 20'h00123;
        bus_if.i_wdata[0 +: DW] = 16'hBEEF;
        start_round(4'b0011);
        chk("t5_wr", {bus_if.o_sram_addr, bus_if.o_sram_wdata,
                      bus_if.o_sram_we_n, bus_if.o_sram_drive},
                     {20'h00123, 16'hBEEF, 1'b0, 1'b1});
        repeat (3) step();
        chk("t5_gap", {bus_if.o_grant, bus_if.o_busy,
                       bus_if.o_sram_we_n, bus_if.o_sram_drive},
                      {4'b0000, 1'b1, 1'b1, 1'b0});
        run_round("t5", n, cnt, gaps);
        bus_if.i_we_n = '1;
        step();

        // empty round completes immediately
        start_round(4'b0000);
        chk("t6_empty", {bus_if.o_grant, bus_if.o_busy, bus_if.o_round_done},
                        {4'b0000, 1'b0, 1'b1});

        // random rounds
        rnd_mode = 1'b1;
        repeat (3000) step();
        rnd_mode = 1'b0;
        bus_if.i_start = 0;
        bus_if.i_clr_status = 0;
        repeat (200) step();

        // reset mid-grant takes effect without a clock edge
        set_hold(10);
        start_round(4'b1111);
        step();
        step();
        chk("t6_pre", 64'(bus_if.o_grant), 64'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst", {bus_if.o_grant, bus_if.o_busy, bus_if.o_sram_we_n,
                       bus_if.o_sram_drive, bus_if.o_timeout},
                      {4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000});
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
